// File: rtl/seletor_tela.sv
// seletor_tela: screen-state controller and registered RGB output stage.
//
// Owns the INICIAL/JOGO/VITORIA/DERROTA game-state FSM. Screens change only
// on the frame tick (first blanking pixel after the visible area), so no
// frame ever shows two screens. Also generates the frame-paced `troca`
// blink toggle.
//
// Optional build macro: SELETOR_TELA_DEBOUNCE_EN
//   defined   -> btn_start is debounced (DEBOUNCE_CYCLES stable clocks)
//   undefined -> btn_start edge is taken straight from the synchronizer
//
// Ports:
//   clk          pixel clock
//   reset        asynchronous, active-low reset
//   h_counter    current pixel column (10 bits)
//   v_counter    current line (10 bits)
//   btn_start    start pushbutton, asynchronous, active-high
//   evt_vitoria  one-cycle victory pulse
//   evt_derrota  one-cycle defeat pulse
//   rgb_*        24-bit {R,G,B} pixels from each screen generator
//   R, G, B      registered pixel to the DAC (1 clk latency)
//   troca        blink toggle
//   estado       0=INICIAL 1=JOGO 2=VITORIA 3=DERROTA
//   jogo_reset   one-cycle pulse when JOGO is entered
module seletor_tela #(
    parameter int H_ACTIVE        = 640,
    parameter int V_ACTIVE        = 480,
    parameter int BLINK_FRAMES    = 30,
    parameter int RESULT_FRAMES   = 300,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  h_counter,
    input  logic [9:0]  v_counter,
    input  logic        btn_start,
    input  logic        evt_vitoria,
    input  logic        evt_derrota,
    input  logic [23:0] rgb_inicial,
    input  logic [23:0] rgb_jogo,
    input  logic [23:0] rgb_vitoria,
    input  logic [23:0] rgb_derrota,
    output logic [7:0]  R,
    output logic [7:0]  G,
    output logic [7:0]  B,
    output logic        troca,
    output logic [1:0]  estado,
    output logic        jogo_reset
);

    localparam logic [1:0] INICIAL = 2'd0;
    localparam logic [1:0] JOGO    = 2'd1;
    localparam logic [1:0] VITORIA = 2'd2;
    localparam logic [1:0] DERROTA = 2'd3;

    localparam logic [9:0] H_END = 10'(H_ACTIVE);
    localparam logic [9:0] V_END = 10'(V_ACTIVE);

    localparam int BW = (BLINK_FRAMES  > 1) ? $clog2(BLINK_FRAMES)  : 1;
    localparam int RW = (RESULT_FRAMES > 1) ? $clog2(RESULT_FRAMES) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
    localparam logic [RW-1:0] RES_LAST   = RW'(RESULT_FRAMES - 1);

    logic sof;
    logic visible;

    assign sof     = (h_counter == H_END) && (v_counter == V_END);
    assign visible = (h_counter < H_END) && (v_counter < V_END);

    // ---------------- start button ----------------
    logic sync1_q, sync2_q;
    logic lvl, lvl_prev_q;
    logic start_p;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            lvl_prev_q <= 1'b0;
        end else begin
            sync1_q    <= btn_start;
            sync2_q    <= sync1_q;
            lvl_prev_q <= lvl;
        end
    end

`ifdef SELETOR_TELA_DEBOUNCE_EN
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    logic          db_lvl_q, db_lvl_d;
    logic [DW-1:0] db_cnt_q, db_cnt_d;

    // Counter runs only while the synchronized level disagrees with the
    // debounced one; any return to agreement restarts the count.
    always_comb begin
        db_lvl_d = db_lvl_q;
        db_cnt_d = '0;
        if (sync2_q != db_lvl_q) begin
            if (db_cnt_q == DB_LAST) begin
                db_lvl_d = sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            db_lvl_q <= 1'b0;
            db_cnt_q <= '0;
        end else begin
            db_lvl_q <= db_lvl_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    assign lvl = db_lvl_q;
`else
    logic unused_db;
    assign unused_db = (DEBOUNCE_CYCLES == 0);
    assign lvl       = sync2_q;
`endif

    assign start_p = lvl & ~lvl_prev_q;

    // ---------------- game-state FSM ----------------
    logic [1:0]    estado_q, estado_d;
    logic          pend_vld_q, pend_vld_d;
    logic [1:0]    pend_q, pend_d;
    logic [RW-1:0] res_cnt_q, res_cnt_d;
    logic          jogo_reset_q, jogo_reset_d;
    logic          req_vld;
    logic [1:0]    req_st;
    logic          timeout;
    logic          next_vld;
    logic [1:0]    next_st;

    assign timeout = sof && (res_cnt_q == RES_LAST);

    always_comb begin
        req_vld = 1'b0;
        req_st  = INICIAL;
        case (estado_q)
            INICIAL: begin
                if (start_p) begin
                    req_vld = 1'b1;
                    req_st  = JOGO;
                end
            end
            JOGO: begin
                if (evt_derrota) begin
                    req_vld = 1'b1;
                    req_st  = DERROTA;
                end else if (evt_vitoria) begin
                    req_vld = 1'b1;
                    req_st  = VITORIA;
                end
            end
            default: begin
                if (start_p || timeout) begin
                    req_vld = 1'b1;
                    req_st  = INICIAL;
                end
            end
        endcase
    end

    // A request arriving on the sof cycle itself is applied at that sof.
    assign next_vld = pend_vld_q | req_vld;
    assign next_st  = pend_vld_q ? pend_q : req_st;

    always_comb begin
        estado_d     = estado_q;
        pend_vld_d   = pend_vld_q;
        pend_d       = pend_q;
        res_cnt_d    = res_cnt_q;
        jogo_reset_d = 1'b0;
        if (!pend_vld_q && req_vld) begin
            pend_vld_d = 1'b1;
            pend_d     = req_st;
        end
        if (sof) begin
            if (estado_q == VITORIA || estado_q == DERROTA) begin
                res_cnt_d = res_cnt_q + 1'b1;
            end
            if (next_vld) begin
                estado_d     = next_st;
                pend_vld_d   = 1'b0;
                res_cnt_d    = '0;
                jogo_reset_d = (next_st == JOGO);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado_q     <= INICIAL;
            pend_vld_q   <= 1'b0;
            pend_q       <= INICIAL;
            res_cnt_q    <= '0;
            jogo_reset_q <= 1'b0;
        end else begin
            estado_q     <= estado_d;
            pend_vld_q   <= pend_vld_d;
            pend_q       <= pend_d;
            res_cnt_q    <= res_cnt_d;
            jogo_reset_q <= jogo_reset_d;
        end
    end

    // ---------------- blink toggle ----------------
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          troca_q, troca_d;

    always_comb begin
        blink_cnt_d = blink_cnt_q;
        troca_d     = troca_q;
        if (sof) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = '0;
                troca_d     = ~troca_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blink_cnt_q <= '0;
            troca_q     <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            troca_q     <= troca_d;
        end
    end

    // ---------------- pixel path ----------------
    logic [23:0] rgb_q, rgb_d;

    always_comb begin
        rgb_d = '0;
        if (visible) begin
            case (estado_q)
                INICIAL: rgb_d = rgb_inicial;
                JOGO:    rgb_d = rgb_jogo;
                VITORIA: rgb_d = rgb_vitoria;
                default: rgb_d = rgb_derrota;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rgb_q <= '0;
        end else begin
            rgb_q <= rgb_d;
        end
    end

    assign R          = rgb_q[23:16];
    assign G          = rgb_q[15:8];
    assign B          = rgb_q[7:0];
    assign troca      = troca_q;
    assign estado     = estado_q;
    assign jogo_reset = jogo_reset_q;

endmodule

// File: tb/tb_seletor_tela.sv
// Bench for seletor_tela: directed steps followed by a random phase, all
// checked every clock against a frame-level behavioural model.
module tb_seletor_tela;

    localparam int HA = 640;
    localparam int VA = 480;
    localparam int BF = 2;
    localparam int RF = 3;
    localparam int DC = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  h_counter, v_counter;
    logic        btn_start, evt_vitoria, evt_derrota;
    logic [23:0] rgb_inicial, rgb_jogo, rgb_vitoria, rgb_derrota;
    logic [7:0]  R, G, B;
    logic        troca, jogo_reset;
    logic [1:0]  estado;

    always #5 clk = ~clk;

    seletor_tela #(
        .H_ACTIVE(HA), .V_ACTIVE(VA), .BLINK_FRAMES(BF),
        .RESULT_FRAMES(RF), .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clk(clk), .reset(reset),
        .h_counter(h_counter), .v_counter(v_counter),
        .btn_start(btn_start), .evt_vitoria(evt_vitoria), .evt_derrota(evt_derrota),
        .rgb_inicial(rgb_inicial), .rgb_jogo(rgb_jogo),
        .rgb_vitoria(rgb_vitoria), .rgb_derrota(rgb_derrota),
        .R(R), .G(G), .B(B), .troca(troca), .estado(estado), .jogo_reset(jogo_reset)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model state (screen number, pending screen or -1,
    // frames since entering a result screen, frames since reset).
    int          m_est, m_pend, m_fs, m_sofs;
    bit          m_jr;
    logic [23:0] m_rgb;
    bit          b1, b2, b3;      // btn_start as sampled 1, 2, 3 edges ago
    bit          deb, deb_prev;   // debounced level now / one cycle ago
    bit          shist[$];        // last DC synchronized samples

    task automatic model_reset();
        m_est = 0; m_pend = -1; m_fs = 0; m_sofs = 0; m_jr = 0; m_rgb = '0;
        b1 = 0; b2 = 0; b3 = 0; deb = 0; deb_prev = 0;
        shist.delete();
    endtask

    function automatic logic [23:0] screen_pixel(input int st);
        case (st)
            0:       return rgb_inicial;
            1:       return rgb_jogo;
            2:       return rgb_vitoria;
            default: return rgb_derrota;
        endcase
    endfunction

    // Advance the model across one rising clock edge using the inputs
    // that were stable during the preceding cycle.
    task automatic model_edge();
        bit sof, sp, all_new, timeout;
        int ev;
        sof = (h_counter == 10'(HA)) && (v_counter == 10'(VA));
`ifdef SELETOR_TELA_DEBOUNCE_EN
        begin
            bit deb_next;
            shist.push_back(b2);
            if (shist.size() > DC) void'(shist.pop_front());
            deb_next = deb;
            if (shist.size() == DC) begin
                all_new = 1;
                foreach (shist[i]) if (shist[i] == deb) all_new = 0;
                if (all_new) deb_next = ~deb;
            end
            sp = deb & ~deb_prev;
            deb_prev = deb;
            deb = deb_next;
        end
`else
        all_new = 0;
        sp = b2 & ~b3;
`endif
        b3 = b2; b2 = b1; b1 = btn_start;

        if (h_counter >= 10'(HA) || v_counter >= 10'(VA)) m_rgb = '0;
        else m_rgb = screen_pixel(m_est);

        ev = -1;
        timeout = sof && (m_fs + 1 == RF);
        case (m_est)
            0: if (sp) ev = 1;
            1: if (evt_derrota) ev = 3; else if (evt_vitoria) ev = 2;
            default: if (sp || timeout) ev = 0;
        endcase
        if (m_pend < 0 && ev >= 0) m_pend = ev;

        m_jr = 0;
        if (sof) begin
            m_sofs++;
            if (m_est >= 2) m_fs++;
            if (m_pend >= 0) begin
                m_est = m_pend;
                m_pend = -1;
                m_fs = 0;
                m_jr = (m_est == 1);
            end
        end
    endtask

    task automatic check(input string tag);
        bit exp_troca;
        exp_troca = ((m_sofs / BF) % 2) == 1;
        vectors++;
        assert (estado === 2'(m_est)) else begin
            miscompares++;
            $error("FAIL %s estado: got %0d expected %0d", tag, estado, m_est);
        end
        vectors++;
        assert ({R, G, B} === m_rgb) else begin
            miscompares++;
            $error("FAIL %s rgb: got %h expected %h", tag, {R, G, B}, m_rgb);
        end
        vectors++;
        assert (troca === exp_troca) else begin
            miscompares++;
            $error("FAIL %s troca: got %b expected %b", tag, troca, exp_troca);
        end
        vectors++;
        assert (jogo_reset === m_jr) else begin
            miscompares++;
            $error("FAIL %s jogo_reset: got %b expected %b", tag, jogo_reset, m_jr);
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check(tag);
    endtask

    task automatic set_pix(input int h, input int v);
        h_counter = 10'(h);
        v_counter = 10'(v);
    endtask

    task automatic rand_rgb();
        rgb_inicial = 24'($urandom); rgb_jogo    = 24'($urandom);
        rgb_vitoria = 24'($urandom); rgb_derrota = 24'($urandom);
    endtask

    task automatic idle(input int n, input int line, input string tag);
        for (int i = 0; i < n; i++) begin
            set_pix($urandom_range(0, HA - 1), line);
            rand_rgb();
            tick(tag);
        end
    endtask

    task automatic frame_tick(input string tag);
        set_pix(HA, VA);
        tick(tag);
    endtask

    task automatic press(input int hold, input string tag);
        btn_start = 1;
        idle(hold, 100, tag);
        btn_start = 0;
        idle(8, 100, tag);
    endtask

    task automatic expect_state(input logic [1:0] st, input string tag);
        vectors++;
        assert (estado === st) else begin
            miscompares++;
            $error("FAIL %s: estado got %0d expected %0d", tag, estado, st);
        end
    endtask

    initial begin
        reset = 1; btn_start = 0; evt_vitoria = 0; evt_derrota = 0;
        set_pix(0, 0);
        rgb_inicial = '0; rgb_jogo = '0; rgb_vitoria = '0; rgb_derrota = '0;
        #2 reset = 0;
        model_reset();
        #1 check("por_reset");
        repeat (2) @(posedge clk);
        #1 reset = 1;

        // Title pixel appears one clock later.
        set_pix(10, 10);
        rgb_inicial = 24'hFF00FF;
        tick("title_pixel");
        vectors++;
        assert ({R, G, B} === 24'hFF00FF) else begin
            miscompares++;
            $error("FAIL title_ff00ff: got %h expected ff00ff", {R, G, B});
        end

        // Start press on line 100: JOGO only after the frame tick.
        press(8, "start_press");
        idle(10, 200, "wait_sof");
        frame_tick("enter_jogo");
        expect_state(2'd1, "jogo_entered");
        idle(3, 5, "after_jogo");

        // Simultaneous victory + defeat: defeat wins, later victory ignored.
        evt_vitoria = 1; evt_derrota = 1;
        idle(1, 50, "both_evt");
        evt_vitoria = 0; evt_derrota = 0;
        idle(4, 60, "gap");
        evt_vitoria = 1;
        idle(1, 70, "late_vit");
        evt_vitoria = 0;
        idle(4, 80, "gap2");
        frame_tick("enter_derrota");
        expect_state(2'd3, "derrota_wins");

        // Auto-return after RF frames.
        for (int f = 0; f < RF; f++) begin
            idle(5, 30, "result_wait");
            frame_tick("result_sof");
        end
        expect_state(2'd0, "auto_return");

        // Victory, then early return by pressing start after frame 1.
        press(8, "start2");
        frame_tick("jogo2");
        evt_vitoria = 1;
        idle(1, 40, "vit_evt");
        evt_vitoria = 0;
        frame_tick("enter_vit");
        expect_state(2'd2, "vitoria");
        idle(4, 30, "vit_f0");
        frame_tick("vit_sof1");
        press(8, "start_in_vit");
        frame_tick("vit_sof2");
        expect_state(2'd0, "early_return");

        // Blanking forces black output.
        set_pix(700, 10);
        rgb_inicial = '1; rgb_jogo = '1; rgb_vitoria = '1; rgb_derrota = '1;
        tick("blank_h700");
        vectors++;
        assert ({R, G, B} === 24'h000000) else begin
            miscompares++;
            $error("FAIL blank_h700: got %h expected 000000", {R, G, B});
        end

        // Short button glitch; outcome depends on the debounce build.
        press(3, "glitch");
        frame_tick("glitch_sof");

        // Run blink frames.
        for (int f = 0; f < 8; f++) begin
            idle(3, 20, "blink");
            frame_tick("blink_sof");
        end

        // Mid-frame asynchronous reset while in JOGO.
        if (estado != 2'd1) begin
            press(8, "to_jogo");
            frame_tick("to_jogo_sof");
        end
        idle(5, 120, "jogo_mid");
        #3 reset = 0;
        model_reset();
        #1 check("mid_reset");
        @(posedge clk);
        #1 reset = 1;

        // Random phase.
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 9) == 0) btn_start = ~btn_start;
            evt_vitoria = ($urandom_range(0, 19) == 0);
            evt_derrota = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 14) == 0) set_pix(HA, VA);
            else set_pix($urandom_range(0, 799), $urandom_range(0, 524));
            rand_rgb();
            tick("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
